// File: rtl/apb_master_bridge.sv
// APB3 requester bridge. Accepts one command at a time on a valid/ready port
// and runs it as an APB SETUP/ACCESS transfer. Each completion or timeout
// abort is reported as a single-cycle response pulse.
module apb_master_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] PADDR,
    output logic          PSELx,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so the
    // declarations stay legal.
    localparam bit            TO_EN    = (TIMEOUT != 0);
    localparam int            CW       = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the wait cycle that would bring the count to TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

    logic [1:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q,   rsp_err_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [AW-1:0] paddr_q,     paddr_d;
    logic          psel_q,      psel_d;
    logic          penable_q,   penable_d;
    logic          pwrite_q,    pwrite_d;
    logic [DW-1:0] pwdata_q,    pwdata_d;

    // Next-state logic for the IDLE -> SETUP -> ACCESS -> IDLE transfer sequence.
    always_comb begin
        // NOTE: every _d is given its hold value first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_wdata;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                cmd_ready_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears every output and drops any transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign PADDR     = paddr_q;
    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge. A driver issues directed and
// random commands and pushes expected responses into a scoreboard. A slave
// model plays each transfer's planned wait/error/data. A monitor compares
// every response pulse against the scoreboard. A second instance with the
// timeout disabled checks that a stalled transfer stays pending.
module tb_apb_master_bridge;

    localparam int TO = 16;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;   // ACCESS cycles with PREADY low before PREADY high
        logic        err;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          done;    // clock edge index at which rsp_valid must rise
    } exp_t;

    logic        PCLK, PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR;

    logic        nt_cmd_valid, nt_cmd_ready, nt_cmd_write;
    logic [31:0] nt_cmd_addr, nt_cmd_wdata;
    logic        nt_rsp_valid, nt_rsp_err;
    logic [31:0] nt_rsp_rdata;
    logic [31:0] nt_PADDR, nt_PWDATA, nt_PRDATA;
    logic        nt_PSELx, nt_PENABLE, nt_PWRITE, nt_PREADY, nt_PSLVERR;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_done = 0;
    logic [31:0] hold_rdata = '0;
    bit          nt_done = 0;
    exp_t        exp_q[$];
    txn_t        slv_q[$];

    apb_master_bridge #(.AW(32), .DW(32), .TIMEOUT(TO)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_master_bridge #(.AW(32), .DW(32), .TIMEOUT(0)) u_nt (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(nt_cmd_valid), .cmd_ready(nt_cmd_ready), .cmd_write(nt_cmd_write),
        .cmd_addr(nt_cmd_addr), .cmd_wdata(nt_cmd_wdata),
        .rsp_valid(nt_rsp_valid), .rsp_rdata(nt_rsp_rdata), .rsp_err(nt_rsp_err),
        .PADDR(nt_PADDR), .PSELx(nt_PSELx), .PENABLE(nt_PENABLE), .PWRITE(nt_PWRITE),
        .PWDATA(nt_PWDATA), .PRDATA(nt_PRDATA), .PREADY(nt_PREADY), .PSLVERR(nt_PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Edge counter: after rising edge k, cyc == k.
    initial begin
        forever begin
            @(posedge PCLK);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input int waits, input logic e, input logic [31:0] rd);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = wd; t.waits = waits; t.err = e; t.rdata = rd;
        return t;
    endfunction

    // Reference timing: two cycles of SETUP+first ACCESS, plus wait cycles,
    // capped by the watchdog which gives up after TO low-PREADY samples.
    function automatic int lat(input int waits);
        return 2 + ((waits >= TO) ? TO - 1 : waits);
    endfunction

    // Present a command (called at a falling edge) and hold it until accepted.
    // Returns at the falling edge right after the accepting rising edge.
    task automatic issue(input txn_t t, input bit hold, input bit track);
        bit   accepted;
        int   budget;
        int   acc_cyc;
        bit   timed_out;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = t.write;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        accepted  = 0;
        budget    = 0;
        while (!accepted) begin
            check("cmd_ready level", cmd_ready, (cyc >= last_done) ? 1 : 0);
            if (cmd_ready) begin
                accepted = 1;
                acc_cyc  = cyc + 1;
                if (hold)
                    check("back-to-back accept edge", acc_cyc, last_done + 1);
                slv_q.push_back(t);
                if (track) begin
                    timed_out = (t.waits >= TO);
                    e.err     = timed_out ? 1'b1 : t.err;
                    e.rdata   = (timed_out || t.write) ? 32'h0 : t.rdata;
                    e.done    = acc_cyc + lat(t.waits);
                    exp_q.push_back(e);
                    last_done = e.done;
                end
            end else if (budget > 60) begin
                check("command accept within budget", 0, 1);
                accepted = 1;
            end
            budget++;
            @(negedge PCLK);
        end
    endtask

    // Response monitor: pops the scoreboard on every rsp_valid pulse.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (PRESETn) begin
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected rsp_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_err", rsp_err, e.err);
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp latency edge", cyc, e.done);
                        hold_rdata = e.rdata;
                    end
                end else begin
                    check("rsp_err outside pulse", rsp_err, 0);
                    check("rsp_rdata hold", rsp_rdata, hold_rdata);
                end
            end
        end
    end

    // APB completer model: plays each transfer's plan, randomises PREADY,
    // PSLVERR and PRDATA whenever the bridge must ignore them.
    initial begin : slave
        txn_t cur;
        int   acc;
        cur = mk(0, 0, 0, 0, 0, 0);
        acc = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (PSELx && PENABLE) begin
                check("PADDR stable in ACCESS", PADDR, cur.addr);
                check("PWRITE stable in ACCESS", PWRITE, cur.write);
                if (cur.write) check("PWDATA stable in ACCESS", PWDATA, cur.wdata);
                if (acc == cur.waits) begin
                    PREADY = 1'b1; PSLVERR = cur.err; PRDATA = cur.rdata;
                end else begin
                    PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
                end
                acc++;
            end else begin
                PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
                if (PSELx) begin
                    if (slv_q.size() == 0) begin
                        check("unexpected SETUP", 1, 0);
                    end else begin
                        cur = slv_q.pop_front();
                        acc = 0;
                        check("PADDR in SETUP", PADDR, cur.addr);
                        check("PWRITE in SETUP", PWRITE, cur.write);
                        if (cur.write) check("PWDATA in SETUP", PWDATA, cur.wdata);
                    end
                end else if (PRESETn) begin
                    check("PENABLE without PSELx", PENABLE, 0);
                end
            end
        end
    end

    // Timeout-disabled instance: a stalled transfer must stay pending.
    initial begin : no_timeout
        int budget;
        nt_cmd_valid = 1'b0; nt_cmd_write = 1'b0; nt_cmd_addr = 32'h100; nt_cmd_wdata = '0;
        nt_PREADY = 1'b0; nt_PSLVERR = 1'b0; nt_PRDATA = 32'hCAFE_F00D;
        @(posedge PRESETn);
        @(negedge PCLK);
        nt_cmd_valid = 1'b1;
        budget = 0;
        while (!nt_cmd_ready && budget < 10) begin
            @(negedge PCLK);
            budget++;
        end
        check("no-timeout accept", nt_cmd_ready, 1);
        @(negedge PCLK);
        nt_cmd_valid = 1'b0;
        repeat (100) begin
            @(negedge PCLK);
            check("no-timeout PSELx held", nt_PSELx, 1);
            check("no-timeout PENABLE held", nt_PENABLE, 1);
            check("no-timeout no rsp_valid", nt_rsp_valid, 0);
        end
        check("no-timeout PADDR", nt_PADDR, 32'h100);
        check("no-timeout PWRITE", nt_PWRITE, 0);
        check("no-timeout PWDATA", nt_PWDATA, 0);
        check("no-timeout rsp_err", nt_rsp_err, 0);
        check("no-timeout rsp_rdata", nt_rsp_rdata, 0);
        nt_done = 1;
    end

    // Main sequence: reset, directed cases, random traffic, reset mid-transfer.
    initial begin : driver
        txn_t tq[$];
        int   gq[$];
        txn_t t;
        int   r, w, budget;

        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        #12;
        check("reset cmd_ready", cmd_ready, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset PSELx", PSELx, 0);
        check("reset PENABLE", PENABLE, 0);
        check("reset PADDR", PADDR, 0);
        #10 PRESETn = 1'b1;
        #1 check("cmd_ready low before first edge", cmd_ready, 0);
        @(posedge PCLK);
        @(negedge PCLK);
        last_done = cyc;

        // Directed cases, including the timeout boundary (15 waits completes, 16 aborts).
        tq.push_back(mk(1, 32'h40, 32'hDEAD_BEEF, 0, 0, 32'h1111_1111)); gq.push_back(1);
        tq.push_back(mk(0, 32'h10, 32'h0, 2, 0, 32'h1234_5678));         gq.push_back(1);
        tq.push_back(mk(0, 32'h14, 32'h0, 0, 1, 32'hA5A5_A5A5));         gq.push_back(1);
        tq.push_back(mk(0, 32'h18, 32'h0, 20, 0, 32'h7777_7777));        gq.push_back(1);
        tq.push_back(mk(1, 32'h1C, 32'h0BAD_F00D, 15, 0, 32'h0));        gq.push_back(1);
        tq.push_back(mk(0, 32'h20, 32'h0, 16, 0, 32'h3333_3333));        gq.push_back(1);
        tq.push_back(mk(1, 32'h4, 32'hAAAA_5555, 0, 0, 32'h0));          gq.push_back(1);
        tq.push_back(mk(0, 32'h8, 32'h0, 0, 0, 32'h8888_0008));          gq.push_back(0);
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      w = $urandom_range(0, 1);
            else if (r < 9) w = $urandom_range(2, 4);
            else            w = $urandom_range(14, 17);
            tq.push_back(mk(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, w,
                            ($urandom_range(0, 4) == 0), $urandom));
            gq.push_back($urandom_range(0, 2));
        end

        for (int i = 0; i < tq.size(); i++) begin
            if (gq[i] > 0) begin
                cmd_valid = 1'b0;
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
                repeat (gq[i]) @(negedge PCLK);
            end
            issue(tq[i], (i > 0) && (gq[i] == 0), 1);
        end
        cmd_valid = 1'b0;

        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            @(negedge PCLK);
            budget++;
        end
        check("all responses seen", exp_q.size(), 0);

        budget = 0;
        while (!nt_done && budget < 200) begin
            @(negedge PCLK);
            budget++;
        end
        check("no-timeout sequence finished", nt_done, 1);

        // Reset in the middle of an ACCESS phase: transfer vanishes, no response.
        t = mk(1, 32'h24, 32'h5A5A_0F0F, 10, 0, 32'h0);
        issue(t, 0, 0);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        check("PENABLE before mid-transfer reset", PENABLE, 1);
        #2 PRESETn = 1'b0;
        hold_rdata = '0;
        #1;
        check("async reset cmd_ready", cmd_ready, 0);
        check("async reset rsp_valid", rsp_valid, 0);
        check("async reset rsp_err", rsp_err, 0);
        check("async reset rsp_rdata", rsp_rdata, 0);
        check("async reset PSELx", PSELx, 0);
        check("async reset PENABLE", PENABLE, 0);
        check("async reset PADDR", PADDR, 0);
        check("async reset PWRITE", PWRITE, 0);
        check("async reset PWDATA", PWDATA, 0);
        repeat (2) begin
            @(negedge PCLK);
            check("no rsp_valid during reset", rsp_valid, 0);
        end
        #2 PRESETn = 1'b1;
        #1 check("cmd_ready low right after release", cmd_ready, 0);
        @(posedge PCLK);
        @(negedge PCLK);
        check("cmd_ready one edge after release", cmd_ready, 1);
        check("PSELx idle after release", PSELx, 0);
        check("no rsp_valid after release", rsp_valid, 0);
        last_done = cyc;

        // Recovery transfer after reset.
        issue(mk(0, 32'h28, 32'h0, 1, 0, 32'h0F0F_1234), 0, 1);
        cmd_valid = 1'b0;
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(negedge PCLK);
            budget++;
        end
        check("recovery response seen", exp_q.size(), 0);
        repeat (2) @(negedge PCLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
